// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter and its helpers.
//   arb_state_t  : arbiter FSM states
//   MODE_FIXED / MODE_RR : selection policy codes for the MODE parameter
//   MAX_REQ      : largest supported requester count
//   onehot2idx   : one-hot (up to MAX_REQ bits) to binary index
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MAX_REQ    = 8;

  // Bitwise OR of the indices of all set bits; exact for one-hot or zero input.
  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker.
//   req    : request vector
//   ptr    : search start index (used only when MODE = MODE_RR)
//   winner : one-hot winner, zero when req is zero
// MODE_FIXED picks the lowest set index; MODE_RR picks the first set index
// at or after ptr, wrapping modulo N_REQ.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int MODE  = MODE_FIXED,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] winner
);

  logic [IW-1:0]      start;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_win;
  logic [2*N_REQ-1:0] win_dbl;

  assign start = (MODE == MODE_RR) ? ptr : '0;

  // Rotate so the search start lands at bit 0, isolate the lowest set bit,
  // then rotate the one-hot result back into requester numbering.
  assign req_dbl = {req, req} >> start;
  assign rot     = req_dbl[N_REQ-1:0];
  assign rot_win = rot & (~rot + N_REQ'(1));
  assign win_dbl = {rot_win, rot_win} << start;
  assign winner  = win_dbl[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single main-memory port shared by the I/D caches.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-requester level request, held until granted
//   req_addr    : request addresses, requester i at [i*AW +: AW]
//   fill_done   : 1-cycle pulse ending the current fill
//   grant       : registered one-hot grant, zero when idle
//   grant_idx   : binary index of granted requester, zero when idle
//   mem_addr    : latched address of the granted request, zero when idle
//   mem_valid   : high while a grant is active
//   timeout_err : 1-cycle pulse when the watchdog aborts a fill
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int AW      = 16,
  parameter  int MODE    = MODE_FIXED,
  parameter  int TIMEOUT = 64,
  localparam int IW      = $clog2(N_REQ),
  localparam int WDW     = $clog2(TIMEOUT) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic                fill_done,
  output logic [N_REQ-1:0]    grant,
  output logic [IW-1:0]       grant_idx,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_valid,
  output logic                timeout_err
);

  arb_state_t       state;
  logic [IW-1:0]    rr_ptr;
  logic [WDW-1:0]   wd_cnt;
  logic [N_REQ-1:0] winner;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    ptr_next;
  logic [AW-1:0]    win_addr;

  rr_pick #(
    .N_REQ (N_REQ),
    .MODE  (MODE)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (winner)
  );

  assign win_idx  = IW'(onehot2idx(MAX_REQ'(winner)));
  assign ptr_next = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);

  // NOTE: default assignment first so no path leaves win_addr unassigned (no latch).
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_addr = win_addr | req_addr[i*AW +: AW];
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      mem_addr    <= '0;
      mem_valid   <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            state     <= ARB_BUSY;
            grant     <= winner;
            grant_idx <= win_idx;
            mem_addr  <= win_addr;
            mem_valid <= 1'b1;
            wd_cnt    <= '0;
            rr_ptr    <= ptr_next;
          end
        end
        ARB_BUSY: begin
          // Completion takes precedence over the watchdog in the same cycle.
          if (fill_done || wd_cnt == WDW'(TIMEOUT - 1)) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            mem_addr    <= '0;
            mem_valid   <= 1'b0;
            timeout_err <= !fill_done;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_valid_match  : assert property (@(posedge clk) disable iff (!rst_n) mem_valid == |grant);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Two instances: A is 2 requesters,
// fixed priority; B is 4 requesters, round robin. Both use TIMEOUT=8.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  typedef struct {
    int          dut;
    int          idx;
    logic [15:0] addr;
    int          dur;
    bit          to;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_a, grant_a;
  logic [31:0] addr_a;
  logic        fd_a, mv_a, te_a;
  logic [0:0]  gidx_a;
  logic [15:0] maddr_a;
  logic [3:0]  req_b, grant_b;
  logic [63:0] addr_b;
  logic        fd_b, mv_b, te_b;
  logic [1:0]  gidx_b;
  logic [15:0] maddr_b;

  txn_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ptr_m[2];
  bit   busy_m[2];
  int   cnt_m[2];
  txn_t cur_m[2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_REQ(2), .AW(16), .MODE(0), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_addr(addr_a), .fill_done(fd_a),
    .grant(grant_a), .grant_idx(gidx_a), .mem_addr(maddr_a), .mem_valid(mv_a),
    .timeout_err(te_a)
  );

  mem_port_arbiter #(.N_REQ(4), .AW(16), .MODE(1), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_addr(addr_b), .fill_done(fd_b),
    .grant(grant_b), .grant_idx(gidx_b), .mem_addr(maddr_b), .mem_valid(mv_b),
    .timeout_err(te_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected transaction whenever a grant rises, then follows it.
  task automatic mon(input int d, input logic [7:0] g, input logic [2:0] gi,
                     input logic [15:0] ma, input logic mv, input logic te);
    if (!rst_n) begin
      busy_m[d] = 1'b0;
      check("rst_grant", 32'(g), 0);
      check("rst_addr", 32'(ma), 0);
      check("rst_valid", 32'(mv), 0);
      check("rst_terr", 32'(te), 0);
    end else if (busy_m[d]) begin
      if (g != 0) begin
        cnt_m[d]++;
        check("hold_grant", 32'(g), 32'(1) << cur_m[d].idx);
        check("hold_idx", 32'(gi), cur_m[d].idx);
        check("hold_addr", 32'(ma), 32'(cur_m[d].addr));
        check("hold_valid", 32'(mv), 1);
        check("hold_terr", 32'(te), 0);
      end else begin
        busy_m[d] = 1'b0;
        check("busy_len", cnt_m[d], cur_m[d].dur);
        check("timeout_err", 32'(te), 32'(cur_m[d].to));
        check("drop_valid", 32'(mv), 0);
        check("drop_addr", 32'(ma), 0);
      end
    end else if (g != 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(g), 0);
      end else begin
        cur_m[d] = exp_q.pop_front();
        busy_m[d] = 1'b1;
        cnt_m[d] = 1;
        check("txn_dut", d, cur_m[d].dut);
        check("grant", 32'(g), 32'(1) << cur_m[d].idx);
        check("grant_idx", 32'(gi), cur_m[d].idx);
        check("mem_addr", 32'(ma), 32'(cur_m[d].addr));
        check("mem_valid", 32'(mv), 1);
        check("grant_terr", 32'(te), 0);
      end
    end else begin
      check("idle_idx", 32'(gi), 0);
      check("idle_addr", 32'(ma), 0);
      check("idle_valid", 32'(mv), 0);
      check("idle_terr", 32'(te), 0);
    end
  endtask

  always @(negedge clk) mon(0, 8'(grant_a), 3'(gidx_a), maddr_a, mv_a, te_a);
  always @(negedge clk) mon(1, 8'(grant_b), 3'(gidx_b), maddr_b, mv_b, te_b);

  task automatic set_in(input int d, input logic [3:0] rq, input logic fd, input bit rnd_addr);
    if (d == 0) begin
      req_a = rq[1:0];
      fd_a  = fd;
      if (rnd_addr) addr_a = $urandom;
    end else begin
      req_b = rq;
      fd_b  = fd;
      if (rnd_addr) addr_b = {$urandom, $urandom};
    end
  endtask

  // Reference choice: lowest set index (fixed) or first set index from ptr (round robin).
  function automatic int pick(input int d, input logic [3:0] rq);
    int n = (d == 0) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      int j = (d == 0) ? i : (ptr_m[d] + i) % n;
      if (rq[j]) return j;
    end
    return -1;
  endfunction

  // One grant: fill_done in busy cycle c (1-based); c > TO means no completion.
  task automatic run_txn(input int d, input logic [3:0] rq, input int c, input bit rnd_addr);
    txn_t t;
    set_in(d, rq, 1'b0, rnd_addr);
    t.dut = d;
    t.idx = pick(d, rq);
    if (d == 1) ptr_m[1] = (t.idx + 1) % 4;
    t.addr = (d == 0) ? addr_a[t.idx*16 +: 16] : addr_b[t.idx*16 +: 16];
    t.to   = (c > TO);
    t.dur  = t.to ? TO : c;
    exp_q.push_back(t);
    @(posedge clk); #1;
    for (int k = 1; k <= t.dur; k++) begin
      set_in(d, 4'($urandom), k == c, 1'b1);
      @(posedge clk); #1;
    end
    set_in(d, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic gap(input int d, input int g);
    for (int k = 0; k < g; k++) begin
      set_in(d, 4'b0, 1'($urandom), 1'b1);
      @(posedge clk); #1;
    end
    set_in(d, 4'b0, 1'b0, 1'b0);
  endtask

  function automatic int pick_c();
    case ($urandom % 4)
      0:       return TO;
      1:       return TO + 1 + int'($urandom % 3);
      default: return int'($urandom_range(1, TO - 1));
    endcase
  endfunction

  initial begin
    txn_t t;
    rst_n  = 1'b0;
    req_a  = 2'b11;
    addr_a = {16'h4560, 16'h1230};
    fd_a   = 1'b0;
    req_b  = '0;
    addr_b = '0;
    fd_b   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed priority: 0 wins, then 1 after one idle cycle.
    run_txn(0, 4'b0011, 5, 1'b0);
    addr_a = {16'h4560, 16'h1230};
    run_txn(0, 4'b0010, 3, 1'b0);
    // Hold: address and request change while busy.
    addr_a = {16'h0000, 16'hBEE0};
    run_txn(0, 4'b0001, 6, 1'b0);
    // Watchdog abort, then fill_done on the last cycle (no error).
    run_txn(0, 4'b0001, TO + 1, 1'b1);
    run_txn(0, 4'b0010, TO, 1'b1);
    repeat (40) begin
      run_txn(0, 4'($urandom_range(1, 3)), pick_c(), 1'b1);
      gap(0, int'($urandom % 3));
    end

    // Round robin: all requesting gives 0,1,2,3,0.
    repeat (5) run_txn(1, 4'hF, int'($urandom_range(1, 4)), 1'b1);
    repeat (60) begin
      run_txn(1, 4'($urandom_range(1, 15)), pick_c(), 1'b1);
      gap(1, int'($urandom % 3));
    end

    // Asynchronous reset in the middle of a fill.
    set_in(0, 4'b0001, 1'b0, 1'b1);
    t.dut = 0; t.idx = 0; t.addr = addr_a[15:0]; t.dur = 0; t.to = 1'b0;
    exp_q.push_back(t);
    @(posedge clk); #1;
    set_in(0, 4'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant_a), 0);
    check("async_valid", 32'(mv_a), 0);
    check("async_addr", 32'(maddr_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr_m[1] = 0;
    run_txn(1, 4'hF, 2, 1'b1);

    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
